// File: rtl/cache_line_addr_gen_pkg.sv
// Shared field widths and FSM encoding for the cache line address generator.
// The width constants are common with the address-split decoder.
package cache_line_addr_gen_pkg;

    localparam int TAG_W    = 4;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 2;
    localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

    localparam logic [OFFSET_W-1:0] LAST_BEAT = {OFFSET_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Increment that naturally wraps at the line boundary (critical-word-first).
    function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
        return off + {{(OFFSET_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cache_line_addr_gen_if.sv
// Request and memory-port bundle of the cache line address generator.
// The master side is the cache controller / memory model; the slave side is the generator.
interface cache_line_addr_gen_if;
    import cache_line_addr_gen_pkg::*;

    logic                start;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] blk_offset;
    logic                mem_ready;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic [OFFSET_W-1:0] beat_cnt;
    logic                busy;
    logic                done;

    modport master (
        output start, tag, index, blk_offset, mem_ready,
        input  mem_req, mem_addr, beat_cnt, busy, done
    );

    modport slave (
        input  start, tag, index, blk_offset, mem_ready,
        output mem_req, mem_addr, beat_cnt, busy, done
    );

endinterface

// File: rtl/cache_line_addr_gen.sv
// Rebuilds full word addresses of a cache line for refill/writeback bursts,
// critical word first with offset wrap-around; one address per accepted beat.
module cache_line_addr_gen
    import cache_line_addr_gen_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    cache_line_addr_gen_if.slave bus
);

    state_e              state_r, state_s;
    logic [TAG_W-1:0]    tag_r, tag_s;
    logic [INDEX_W-1:0]  index_r, index_s;
    logic [OFFSET_W-1:0] offset_r, offset_s;
    logic [OFFSET_W-1:0] beat_cnt_r, beat_cnt_s;
    logic                mem_req_r, mem_req_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tag_r      <= {TAG_W{1'b0}};
            index_r    <= {INDEX_W{1'b0}};
            offset_r   <= {OFFSET_W{1'b0}};
            beat_cnt_r <= {OFFSET_W{1'b0}};
            mem_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tag_r      <= tag_s;
            index_r    <= index_s;
            offset_r   <= offset_s;
            beat_cnt_r <= beat_cnt_s;
            mem_req_r  <= mem_req_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_s    = state_r;
        tag_s      = tag_r;
        index_s    = index_r;
        offset_s   = offset_r;
        beat_cnt_s = beat_cnt_r;
        mem_req_s  = mem_req_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s    = ST_BURST;
                    tag_s      = bus.tag;
                    index_s    = bus.index;
                    offset_s   = bus.blk_offset;
                    beat_cnt_s = {OFFSET_W{1'b0}};
                    mem_req_s  = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    mem_req_s = 1'b0;
                    busy_s    = 1'b0;
                end
            end
            ST_BURST: begin
                if (bus.mem_ready) begin
                    // The final beat leaves offset untouched so mem_addr keeps the last issued word.
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_s    = ST_DONE;
                        mem_req_s  = 1'b0;
                        done_s     = 1'b1;
                        beat_cnt_s = {OFFSET_W{1'b0}};
                    end else begin
                        offset_s   = next_offset(offset_r);
                        beat_cnt_s = next_offset(beat_cnt_r);
                    end
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                busy_s    = 1'b0;
            end
            default: begin
                state_s    = ST_IDLE;
                mem_req_s  = 1'b0;
                busy_s     = 1'b0;
                beat_cnt_s = {OFFSET_W{1'b0}};
            end
        endcase
    end

    assign bus.mem_addr = {tag_r, index_r, offset_r};
    assign bus.mem_req  = mem_req_r;
    assign bus.beat_cnt = beat_cnt_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_cache_line_addr_gen.sv
// Scoreboard bench for cache_line_addr_gen: stimulus queues hand-computed beat
// addresses, a negedge monitor checks every presented beat and counts done pulses.
module tb_cache_line_addr_gen;

    typedef struct packed {
        logic [9:0] addr;
        logic [1:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   done_cnt;
    exp_t exp_q[$];

    cache_line_addr_gen_if bus();

    cache_line_addr_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare every presented beat against the queue head; pop on acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) done_cnt++;
            if (bus.mem_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
                    check("beat_cnt", 32'(bus.beat_cnt), 32'(exp_q[0].cnt));
                    if (bus.mem_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input logic [39:0] addrs, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({addrs[(3-k)*10 +: 10], 2'(k)});
    endtask

    // Full burst; called at posedge+1 with the DUT idle.
    task automatic burst(input logic [3:0] t, input logic [3:0] i, input logic [1:0] off,
                         input logic [39:0] addrs, input int stall_beat, input int stall_len,
                         input bit poke);
        int req_cycles;
        int stalls;
        int base;
        bit seen;
        req_cycles = 0;
        stalls     = 0;
        seen       = 1'b0;
        base       = done_cnt;
        push_exp(addrs, 4);
        bus.start = 1'b1; bus.tag = t; bus.index = i; bus.blk_offset = off; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.tag = 4'h5; bus.index = 4'hF; bus.blk_offset = ~off;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (stall_beat >= 0 && int'(bus.beat_cnt) == stall_beat && stalls < stall_len) begin
                bus.mem_ready = 1'b0;
                stalls++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            bus.start = poke && (c == 1);
            @(negedge clk);
            if (bus.mem_req) req_cycles++;
            if (bus.done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("burst_cycles", 32'(req_cycles), 32'(4 + stall_len));
        check("busy_in_done", 32'(bus.busy), 32'd1);
        check("addr_hold", 32'(bus.mem_addr), 32'(addrs[9:0]));
        if (poke) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
        check("req_after", 32'(bus.mem_req), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt - base), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag_s);
        check({tag_s, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({tag_s, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag_s, "_beat_cnt"}, 32'(bus.beat_cnt), 32'd0);
        check({tag_s, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag_s, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int base;
        bit reached;
        total = 0; passed = 0; done_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.tag = 4'h0; bus.index = 4'h0; bus.blk_offset = 2'd0; bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_req", 32'(bus.mem_req), 32'd0);

        burst(4'hA, 4'h3, 2'd0, {10'h28C, 10'h28D, 10'h28E, 10'h28F}, -1, 0, 1'b0);
        burst(4'hA, 4'h3, 2'd2, {10'h28E, 10'h28F, 10'h28C, 10'h28D}, -1, 0, 1'b0);
        burst(4'h6, 4'h2, 2'd3, {10'h18B, 10'h188, 10'h189, 10'h18A}, 1, 3, 1'b0);
        burst(4'hA, 4'h3, 2'd1, {10'h28D, 10'h28E, 10'h28F, 10'h28C}, -1, 0, 1'b1);

        // Asynchronous reset after two accepted beats.
        base = done_cnt;
        reached = 1'b0;
        push_exp({10'h31D, 10'h31E, 10'h000, 10'h000}, 2);
        bus.start = 1'b1; bus.tag = 4'hC; bus.index = 4'h7; bus.blk_offset = 2'd1; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 10 && !reached; c++) begin
            if (bus.beat_cnt == 2'd2) reached = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("reached_beat2", 32'(reached), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        check("partial_popped", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("no_done_on_abort", 32'(done_cnt - base), 32'd0);
        burst(4'h3, 4'h9, 2'd1, {10'h0E5, 10'h0E6, 10'h0E7, 10'h0E4}, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
